// File: rtl/crop_frame_sequencer.sv
// crop_frame_sequencer: frame-level controller for the crop datapath.
// Walks the raster position, latches clamped crop origins per frame,
// issues ap_start, gates the pixel stream to in-frame periods and turns the
// datapath's done into a frame_done pulse plus a running frame counter.
module crop_frame_sequencer #(
    parameter int IN_ROWS  = 20,
    parameter int IN_COLS  = 20,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       cfg_valid,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    input  logic                       frame_enable,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       dp_tvalid,
    input  logic                       dp_tready,
    input  logic                       crop_ap_done,
    output logic                       ap_start,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic                       frame_done,
    output logic [15:0]                frame_count,
    output logic                       busy,
    output logic                       cfg_err
);
    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam logic [XW-1:0] X_MAX    = XW'(IN_COLS - OUT_COLS);
    localparam logic [YW-1:0] Y_MAX    = YW'(IN_ROWS - OUT_ROWS);
    localparam logic [XW-1:0] COL_LAST = XW'(IN_COLS - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IN_ROWS - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_r;
    logic [XW-1:0] pend_x0_r;
    logic [YW-1:0] pend_y0_r;
    logic          done_seen_r;

    logic          in_stream_s;
    logic          beat_s;
    logic [XW-1:0] clamp_x_s;
    logic [YW-1:0] clamp_y_s;
    logic          clamped_s;

    // Keep the crop window inside the input frame horizontally.
    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    // Keep the crop window inside the input frame vertically.
    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    // Stream gating, beat detection and config clamping.
    always_comb begin
        in_stream_s   = (state_r == STREAM);
        s_axis_tready = dp_tready & in_stream_s;
        dp_tvalid     = s_axis_tvalid & in_stream_s;
        beat_s        = s_axis_tvalid & dp_tready & in_stream_s;
        clamp_x_s     = clamp_x(cfg_x0);
        clamp_y_s     = clamp_y(cfg_y0);
        clamped_s     = (clamp_x_s != cfg_x0) | (clamp_y_s != cfg_y0);
    end

    // Frame state machine with all registered outputs.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_r     <= IDLE;
            pend_x0_r   <= {XW{1'b0}};
            pend_y0_r   <= {YW{1'b0}};
            done_seen_r <= 1'b0;
            ap_start    <= 1'b0;
            crop_x0     <= {XW{1'b0}};
            crop_y0     <= {YW{1'b0}};
            cnt_col     <= {XW{1'b0}};
            cnt_row     <= {YW{1'b0}};
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            ap_start   <= 1'b0;
            frame_done <= 1'b0;

            if (cfg_valid) begin
                pend_x0_r <= clamp_x_s;
                pend_y0_r <= clamp_y_s;
                cfg_err   <= clamped_s;
            end

            case (state_r)
                IDLE: begin
                    cnt_col <= {XW{1'b0}};
                    cnt_row <= {YW{1'b0}};
                    if (frame_enable) begin
                        // A config arriving on the start edge wins over the pending one.
                        crop_x0     <= cfg_valid ? clamp_x_s : pend_x0_r;
                        crop_y0     <= cfg_valid ? clamp_y_s : pend_y0_r;
                        done_seen_r <= 1'b0;
                        ap_start    <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= START;
                    end
                end
                START: begin
                    // Any done seen here belongs to no frame and is dropped.
                    done_seen_r <= 1'b0;
                    state_r     <= STREAM;
                end
                STREAM: begin
                    if (crop_ap_done) begin
                        done_seen_r <= 1'b1;
                    end
                    if (beat_s) begin
                        if (cnt_col == COL_LAST) begin
                            cnt_col <= {XW{1'b0}};
                            if (cnt_row == ROW_LAST) begin
                                cnt_row <= {YW{1'b0}};
                                state_r <= DRAIN;
                            end else begin
                                cnt_row <= cnt_row + Y_ONE;
                            end
                        end else begin
                            cnt_col <= cnt_col + X_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (done_seen_r | crop_ap_done) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        done_seen_r <= 1'b0;
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/crop_frame_sequencer.md
Name: crop_frame_sequencer

Overview:
- Frame-level controller for the crop datapath.
- Generates the raster position (cnt_col/cnt_row) and applies per-frame crop coordinates with clamping.
- Issues ap_start, gates the pixel stream so it only flows inside a frame, and collects the crop datapath's done into a frame_done pulse plus a frame counter.
- Sits between the upstream pixel AXIS source and the crop datapath's slave port/control pins.

Parameters:
- IN_ROWS, 20, input frame height in pixels.
- IN_COLS, 20, input frame width in pixels.
- OUT_ROWS, 10, crop window height; must be <= IN_ROWS.
- OUT_COLS, 10, crop window width; must be <= IN_COLS.

Ports:
- clk  in  1  clock.
- srst  in  1  reset; asynchronous, active-high.
- cfg_valid  in  1  single-cycle strobe; capture cfg_x0/cfg_y0 into the pending config.
- cfg_x0  in  $clog2(IN_COLS)  requested crop column origin.
- cfg_y0  in  $clog2(IN_ROWS)  requested crop row origin.
- frame_enable  in  1  level; permits the next frame to start.
- s_axis_tvalid  in  1  upstream pixel valid.
- s_axis_tready  out  1  ready to upstream; equals dp_tready AND (state==STREAM).
- dp_tvalid  out  1  valid to the datapath; equals s_axis_tvalid AND (state==STREAM).
- dp_tready  in  1  datapath slave ready.
- crop_ap_done  in  1  done from the datapath; may be a 1-cycle pulse.
- ap_start  out  1  1-cycle start pulse to the datapath.
- crop_x0  out  $clog2(IN_COLS)  active-frame crop column origin (registered).
- crop_y0  out  $clog2(IN_ROWS)  active-frame crop row origin (registered).
- cnt_col  out  $clog2(IN_COLS)  column of the current pixel.
- cnt_row  out  $clog2(IN_ROWS)  row of the current pixel.
- frame_done  out  1  1-cycle pulse at frame completion.
- frame_count  out  16  completed frames; wraps at 65535 -> 0.
- busy  out  1  high whenever state != IDLE.
- cfg_err  out  1  high if the last captured config was clamped.

Behaviour:
Reset (srst asserted, asynchronous):
- State = IDLE.
- All outputs 0; pending config = 0; done_seen = 0; cfg_err = 0.
- A reset mid-frame abandons the frame: counters go to 0, no frame_done is issued, frame_count is retained only across non-reset cycles (it is also cleared).

Pixel beat:
- beat = s_axis_tvalid AND s_axis_tready. Counters move only on a beat.

Config capture:
- On cfg_valid, x0 is clamped to min(cfg_x0, IN_COLS-OUT_COLS) and y0 to min(cfg_y0, IN_ROWS-OUT_ROWS).
- The clamped values are stored as pending config.
- cfg_err is set to 1 if either value was clamped, otherwise 0. It updates only on cfg_valid.
- Pending config is copied to crop_x0/crop_y0 only on the IDLE->START transition; mid-frame cfg_valid affects the next frame only.
- If cfg_valid coincides with the IDLE->START transition, the new clamped value is the one applied.

State machine:
- IDLE: counters held at 0. If frame_enable=1 at clock edge N: latch crop_x0/crop_y0, clear done_seen, go to START.
- START: ap_start=1 for exactly this one cycle (cycle N+1). Go to STREAM.
- STREAM: s_axis_tready/dp_tvalid are passed through. On a beat:
  - if cnt_col == IN_COLS-1: cnt_col -> 0 and cnt_row increments;
  - otherwise cnt_col increments.
  - On the beat at (IN_ROWS-1, IN_COLS-1): counters -> 0 and go to DRAIN.
- DRAIN: upstream is stalled (s_axis_tready=0). When done_seen=1 or crop_ap_done=1: frame_done=1 for one cycle, frame_count increments, go to IDLE.
- done_seen: set by crop_ap_done in STREAM or DRAIN; cleared in START. A done that arrives before the last pixel is therefore not lost.
- Frame_done latency: if done has already been seen, frame_done is asserted the cycle after entering DRAIN.
- crop_ap_done in IDLE or START is ignored.
- Back-to-back frames: if frame_enable stays high, the next START follows IDLE by one cycle. Minimum inter-frame gap is 3 cycles (DRAIN, IDLE, START).
- Combinational outputs: s_axis_tready and dp_tvalid. All other outputs are registered.

Test Plan:
- Basic frame: cfg (5,3), frame_enable=1, dp_tready=1, source always valid, crop_ap_done pulsed after 100th in-window beat.
  - ap_start exactly once, 1 cycle after enable.
  - crop_x0=5, crop_y0=3.
  - 400 beats with cnt_col 0..19 repeating and cnt_row 0..19.
  - frame_done once; frame_count=1; busy low afterwards.
- Clamp: cfg (15,12) -> crop_x0=10, crop_y0=10, cfg_err=1. A following cfg (2,2) -> cfg_err=0; applied on the next frame.
- Backpressure: dp_tready random 50%, s_axis_tvalid random 70%.
  - Counters advance only on beats; total beats exactly 400.
  - dp_tvalid never high outside STREAM.
- Early done / late done:
  - done pulsed mid-STREAM -> frame_done 1 cycle after DRAIN entry.
  - done pulsed 10 cycles into DRAIN -> frame_done the following cycle; s_axis_tready=0 throughout DRAIN.
- Mid-frame config: cfg_valid (7,7) at beat 150.
  - crop_x0/crop_y0 unchanged until the next START, then read (7,7).
  - Simultaneous cfg_valid and IDLE->START applies the new value.
- Async reset at beat 200: all outputs 0 immediately (before the next edge); no frame_done; the next frame restarts at (0,0) with ap_start.
